// File: rtl/zstr_ser.sv
// Stream serializer: one N*BW-bit input word is emitted as N consecutive BW-bit beats
// over a vld/ack handshake, with the final beat of each word flagged on zo_lst.
module zstr_ser #(
   parameter int unsigned BW  = 8,
   parameter int unsigned N   = 4,
   parameter int unsigned ORD = 0
) (
   input  logic            z_clk,
   input  logic            z_rst_n,
   input  logic            zi_vld,
   input  logic [N*BW-1:0] zi_bus,
   output logic            zi_ack,
   output logic            zo_vld,
   output logic [BW-1:0]   zo_bus,
   output logic            zo_lst,
   input  logic            zo_ack
);

   localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned WW   = N * BW;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   logic          lo_vld_q, lo_vld_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WW-1:0] sh_q, sh_d;
   logic [CW-1:0] sel;

   // Output decode from registered state only; zo_ack -> zi_ack is the sole comb path
   always_comb begin
      zo_vld = lo_vld_q;
      zo_lst = (cnt_q == LAST);
      zi_ack = ~lo_vld_q | (zo_ack & zo_lst);
      sel    = (ORD == 0) ? cnt_q : (LAST - cnt_q);
      zo_bus = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (sel == CW'(k)) zo_bus = sh_q[k*BW +: BW];
      end
   end

   // A new word beats an outgoing last beat, so words chain with no bubble
   always_comb begin
      lo_vld_d = lo_vld_q;
      cnt_d    = cnt_q;
      sh_d     = sh_q;
      if (zi_vld && zi_ack) begin
         sh_d     = zi_bus;
         cnt_d    = '0;
         lo_vld_d = 1'b1;
      end else if (lo_vld_q && zo_ack && zo_lst) begin
         lo_vld_d = 1'b0;
         cnt_d    = '0;
      end else if (lo_vld_q && zo_ack) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge z_clk or negedge z_rst_n) begin
      if (!z_rst_n) begin
         lo_vld_q <= 1'b0;
         cnt_q    <= '0;
         sh_q     <= '0;
      end else begin
         lo_vld_q <= lo_vld_d;
         cnt_q    <= cnt_d;
         sh_q     <= sh_d;
      end
   end

endmodule

// File: tb/tb_zstr_ser.sv
// Scoreboard bench for zstr_ser: LSB-first, MSB-first and single-beat (N=1) instances.
module tb_zstr_ser;

   logic clk, rst_n;

   logic        a_vld, a_ack, a_ovld, a_olst, a_oack;
   logic [31:0] a_bus;
   logic [7:0]  a_obus;
   logic        b_vld, b_ack, b_ovld, b_olst, b_oack;
   logic [31:0] b_bus;
   logic [7:0]  b_obus;
   logic        c_vld, c_ack, c_ovld, c_olst, c_oack;
   logic [31:0] c_bus, c_obus;

   int n_cmp = 0;
   int n_bad = 0;

   logic [8:0]  qa[$];
   logic [8:0]  qb[$];
   logic [31:0] qc[$];

   zstr_ser #(.BW(8), .N(4), .ORD(0)) u_a (
      .z_clk(clk), .z_rst_n(rst_n), .zi_vld(a_vld), .zi_bus(a_bus), .zi_ack(a_ack),
      .zo_vld(a_ovld), .zo_bus(a_obus), .zo_lst(a_olst), .zo_ack(a_oack));

   zstr_ser #(.BW(8), .N(4), .ORD(1)) u_b (
      .z_clk(clk), .z_rst_n(rst_n), .zi_vld(b_vld), .zi_bus(b_bus), .zi_ack(b_ack),
      .zo_vld(b_ovld), .zo_bus(b_obus), .zo_lst(b_olst), .zo_ack(b_oack));

   zstr_ser #(.BW(32), .N(1), .ORD(0)) u_c (
      .z_clk(clk), .z_rst_n(rst_n), .zi_vld(c_vld), .zi_bus(c_bus), .zi_ack(c_ack),
      .zo_vld(c_ovld), .zo_bus(c_obus), .zo_lst(c_olst), .zo_ack(c_oack));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitors: pop one expectation per output transfer
   always @(negedge clk) begin
      if (rst_n && a_ovld && a_oack) begin
         if (qa.size() == 0) chk("a_unexpected_beat", 64'({a_olst, a_obus}), 64'h1ff);
         else chk("a_beat", 64'({a_olst, a_obus}), 64'(qa.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (rst_n && b_ovld && b_oack) begin
         if (qb.size() == 0) chk("b_unexpected_beat", 64'({b_olst, b_obus}), 64'h1ff);
         else chk("b_beat", 64'({b_olst, b_obus}), 64'(qb.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (rst_n && c_ovld && c_oack) begin
         if (qc.size() == 0) chk("c_unexpected_word", 64'(c_obus), 64'hffff_ffff_ffff);
         else chk("c_word", 64'(c_obus), 64'(qc.pop_front()));
         chk("c_lst", 64'(c_olst), 64'd1);
      end
   end

   initial begin
      logic [7:0] e1 [4] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
      logic [7:0] e2 [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      logic [7:0] e4 [4] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA};
      logic [7:0] e5 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
      logic       mvld;
      logic       exp_ack;

      rst_n = 1'b0;
      a_vld = 0; a_bus = '0; a_oack = 0;
      b_vld = 0; b_bus = '0; b_oack = 0;
      c_vld = 0; c_bus = '0; c_oack = 0;
      #2;
      chk("rst_a_vld", 64'(a_ovld), 64'd0);
      chk("rst_a_lst", 64'(a_olst), 64'd0);
      chk("rst_a_bus", 64'(a_obus), 64'd0);
      chk("rst_a_ack", 64'(a_ack), 64'd1);
      chk("rst_b_ack", 64'(b_ack), 64'd1);
      chk("rst_c_lst", 64'(c_olst), 64'd1);
      chk("rst_c_vld", 64'(c_ovld), 64'd0);
      #10;
      rst_n = 1'b1;
      step();

      // Single word, LSB first
      a_vld = 1; a_bus = 32'hDDCCBBAA; a_oack = 1;
      qa.push_back({1'b0, 8'hAA}); qa.push_back({1'b0, 8'hBB});
      qa.push_back({1'b0, 8'hCC}); qa.push_back({1'b1, 8'hDD});
      #1 chk("t1_idle_ack", 64'(a_ack), 64'd1);
      step();
      a_vld = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t1_vld", 64'(a_ovld), 64'd1);
         chk("t1_bus", 64'(a_obus), 64'(e1[i]));
         chk("t1_lst", 64'(a_olst), 64'(i == 3));
         step();
      end
      chk("t1_idle", 64'(a_ovld), 64'd0);

      // Back-to-back words, no bubble
      a_vld = 1; a_bus = 32'h44332211;
      qa.push_back({1'b0, 8'h11}); qa.push_back({1'b0, 8'h22});
      qa.push_back({1'b0, 8'h33}); qa.push_back({1'b1, 8'h44});
      #1 chk("t2_idle_ack", 64'(a_ack), 64'd1);
      step();
      a_bus = 32'h88776655;
      qa.push_back({1'b0, 8'h55}); qa.push_back({1'b0, 8'h66});
      qa.push_back({1'b0, 8'h77}); qa.push_back({1'b1, 8'h88});
      for (int i = 0; i < 8; i++) begin
         if (i == 4) a_vld = 0;
         #1;
         chk("t2_vld", 64'(a_ovld), 64'd1);
         chk("t2_bus", 64'(a_obus), 64'(e2[i]));
         chk("t2_ack", 64'(a_ack), 64'(i == 3 || i == 7));
         step();
      end
      chk("t2_idle", 64'(a_ovld), 64'd0);

      // Backpressure on beat BB
      a_vld = 1; a_bus = 32'hDDCCBBAA; a_oack = 1;
      qa.push_back({1'b0, 8'hAA}); qa.push_back({1'b0, 8'hBB});
      qa.push_back({1'b0, 8'hCC}); qa.push_back({1'b1, 8'hDD});
      step();
      a_vld = 0;
      step();
      for (int k = 0; k < 3; k++) begin
         a_oack = 0;
         #1;
         chk("t3_bus", 64'(a_obus), 64'hBB);
         chk("t3_vld", 64'(a_ovld), 64'd1);
         chk("t3_lst", 64'(a_olst), 64'd0);
         chk("t3_ack", 64'(a_ack), 64'd0);
         step();
      end
      a_oack = 1;
      #1 chk("t3_hold_bus", 64'(a_obus), 64'hBB);
      step();
      chk("t3_resume", 64'(a_obus), 64'hCC);
      step();
      chk("t3_last", 64'({a_olst, a_obus}), 64'h1DD);
      step();
      chk("t3_idle", 64'(a_ovld), 64'd0);

      // MSB-first instance
      b_vld = 1; b_bus = 32'hDDCCBBAA; b_oack = 1;
      qb.push_back({1'b0, 8'hDD}); qb.push_back({1'b0, 8'hCC});
      qb.push_back({1'b0, 8'hBB}); qb.push_back({1'b1, 8'hAA});
      step();
      b_vld = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t4_bus", 64'(b_obus), 64'(e4[i]));
         chk("t4_lst", 64'(b_olst), 64'(i == 3));
         step();
      end
      chk("t4_idle", 64'(b_ovld), 64'd0);

      // N=1 register slice: random traffic, then sustained full rate
      mvld = 1'b0;
      for (int i = 0; i < 60; i++) begin
         c_vld  = (i >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
         c_bus  = $urandom;
         c_oack = (i >= 40) ? 1'b1 : 1'($urandom_range(0, 1));
         #1;
         exp_ack = !mvld || c_oack;
         chk("t6_ack", 64'(c_ack), 64'(exp_ack));
         if (i >= 41) chk("t6_rate", 64'(c_ovld), 64'd1);
         if (c_vld && exp_ack) begin
            qc.push_back(c_bus);
            mvld = 1'b1;
         end else if (mvld && c_oack) begin
            mvld = 1'b0;
         end
         step();
      end
      c_vld = 0; c_oack = 1;
      step();
      step();
      chk("t6_idle", 64'(c_ovld), 64'd0);

      // Reset in the middle of a word
      a_vld = 1; a_bus = 32'hDDCCBBAA; a_oack = 1;
      qa.push_back({1'b0, 8'hAA});
      step();
      a_vld = 0;
      step();
      rst_n = 1'b0;
      #1;
      chk("t5_rst_vld", 64'(a_ovld), 64'd0);
      chk("t5_rst_ack", 64'(a_ack), 64'd1);
      chk("t5_rst_bus", 64'(a_obus), 64'd0);
      step();
      step();
      rst_n = 1'b1;
      step();
      a_vld = 1; a_bus = 32'h04030201;
      qa.push_back({1'b0, 8'h01}); qa.push_back({1'b0, 8'h02});
      qa.push_back({1'b0, 8'h03}); qa.push_back({1'b1, 8'h04});
      #1 chk("t5_ack", 64'(a_ack), 64'd1);
      step();
      a_vld = 0;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("t5_bus", 64'(a_obus), 64'(e5[i]));
         chk("t5_lst", 64'(a_olst), 64'(i == 3));
         step();
      end
      chk("t5_idle", 64'(a_ovld), 64'd0);

      step();
      chk("qa_drained", 64'(qa.size()), 64'd0);
      chk("qb_drained", 64'(qb.size()), 64'd0);
      chk("qc_drained", 64'(qc.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
